// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the fetch and load/store requesters.
// Issues one access per cycle and gives data priority unless fetch has been
// starved for STARVE_LIMIT cycles. A tag pipeline that matches the memory
// latency routes each read response back to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ireq_valid,
  input  logic [ADDR_WIDTH-1:0]   ireq_addr,
  output logic                    ireq_ready,
  output logic                    iresp_valid,
  output logic [DATA_WIDTH-1:0]   iresp_data,
  input  logic                    iflush,
  input  logic                    dreq_valid,
  input  logic [DATA_WIDTH/8-1:0] dreq_we,
  input  logic [ADDR_WIDTH-1:0]   dreq_addr,
  input  logic [DATA_WIDTH-1:0]   dreq_wdata,
  output logic                    dreq_ready,
  output logic                    dresp_valid,
  output logic [DATA_WIDTH-1:0]   dresp_data,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                  fetch_win;
  logic                  data_win;
  logic                  rd_issue;
  logic [3:0]            starve_cnt;
  logic [RD_LATENCY-1:0] vld_p;
  logic [RD_LATENCY-1:0] src_p;   // 1 = fetch, 0 = data
  logic                  out_vld;
  logic                  out_src;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_MAX) ? STARVE_MAX : v + 4'd1;
  endfunction

  // Pick one winner: data first, fetch once it has been starved long enough.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (!rst) begin
      if (ireq_valid && (!dreq_valid || starve_cnt == STARVE_MAX))
        fetch_win = 1'b1;
      else if (dreq_valid)
        data_win = 1'b1;
    end
  end

  assign ireq_ready = fetch_win;
  assign dreq_ready = data_win;
  assign stall      = (ireq_valid & ~ireq_ready) | (dreq_valid & ~dreq_ready);
  assign rd_issue   = fetch_win | (data_win & ~(|dreq_we));

  // Drive the memory port from the winner; an idle port is all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_win) begin
      mem_en   = 1'b1;
      mem_addr = ireq_addr;
    end else if (data_win) begin
      mem_en    = 1'b1;
      mem_we    = dreq_we;
      mem_addr  = dreq_addr;
      mem_wdata = dreq_wdata;
    end
  end

  // Count consecutive cycles a pending fetch has lost arbitration.
  always_ff @(posedge clk) begin
    if (rst || !ireq_valid || fetch_win)
      starve_cnt <= 4'd0;
    else
      starve_cnt <= sat_inc(starve_cnt);
  end

  // Tag valid pipeline; a flush kills fetch tags as they advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_issue;
      for (int i = 1; i < RD_LATENCY; i++)
        vld_p[i] <= vld_p[i-1] & ~(iflush & src_p[i-1]);
    end
  end

  // Tag source pipeline travels alongside the valid bits.
  always_ff @(posedge clk) begin
    src_p[0] <= fetch_win;
    for (int i = 1; i < RD_LATENCY; i++)
      src_p[i] <= src_p[i-1];
  end

  // Final stage steers mem_rdata to its originator; a flush also masks it.
  assign out_vld     = vld_p[RD_LATENCY-1] & ~rst;
  assign out_src     = src_p[RD_LATENCY-1];
  assign iresp_valid = out_vld & out_src & ~iflush;
  assign dresp_valid = out_vld & ~out_src;
  assign iresp_data  = iresp_valid ? mem_rdata : '0;
  assign dresp_data  = dresp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with read latency 1 driven by a
// vector table, and one with latency 3 for flush and reset-in-flight cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iflush;
  logic        dreq_valid;
  logic [3:0]  dreq_we;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;

  logic        ireq_ready_1, iresp_valid_1, dreq_ready_1, dresp_valid_1, mem_en_1, stall_1;
  logic [31:0] iresp_data_1, dresp_data_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [3:0]  mem_we_1;
  logic        ireq_ready_3, iresp_valid_3, dreq_ready_3, dresp_valid_3, mem_en_3, stall_3;
  logic [31:0] iresp_data_3, dresp_data_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [3:0]  mem_we_3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready_1),
    .iresp_valid(iresp_valid_1), .iresp_data(iresp_data_1), .iflush(iflush),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dreq_ready(dreq_ready_1), .dresp_valid(dresp_valid_1), .dresp_data(dresp_data_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .stall(stall_1)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready_3),
    .iresp_valid(iresp_valid_3), .iresp_data(iresp_data_3), .iflush(iflush),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dreq_ready(dreq_ready_3), .dresp_valid(dresp_valid_3), .dresp_data(dresp_data_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .stall(stall_3)
  );

  // Behavioural write-first BRAMs; each word preloads to 0xA0000000 | byte address.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1;
  logic [31:0] rd3_p [3];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'hA000_0000 | (32'(i) << 2);
      rd1 <= '0;
    end else if (mem_en_1) begin
      mem1[mem_addr_1[9:2]] <= merge(mem1[mem_addr_1[9:2]], mem_wdata_1, mem_we_1);
      rd1 <= merge(mem1[mem_addr_1[9:2]], mem_wdata_1, mem_we_1);
    end
  end
  assign mem_rdata_1 = rd1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'hA000_0000 | (32'(i) << 2);
      for (int j = 0; j < 3; j++) rd3_p[j] <= '0;
    end else begin
      if (mem_en_3) begin
        mem3[mem_addr_3[9:2]] <= merge(mem3[mem_addr_3[9:2]], mem_wdata_3, mem_we_3);
        rd3_p[0] <= merge(mem3[mem_addr_3[9:2]], mem_wdata_3, mem_we_3);
      end
      rd3_p[1] <= rd3_p[0];
      rd3_p[2] <= rd3_p[1];
    end
  end
  assign mem_rdata_3 = rd3_p[2];

  typedef struct {
    logic        rst;
    logic        ivld;
    logic [31:0] iaddr;
    logic        dvld;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        flush;
    logic        e_ir;
    logic        e_dr;
    logic        e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_iv;
    logic [31:0] e_id;
    logic        e_dv;
    logic [31:0] e_dd;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd,
                       input logic fl);
    rst = r; ireq_valid = iv; ireq_addr = ia; dreq_valid = dv;
    dreq_we = we; dreq_addr = da; dreq_wdata = wd; iflush = fl;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic chk3_zero(input string tag);
    chk({tag, " ireq_ready"},  32'(ireq_ready_3),  0);
    chk({tag, " dreq_ready"},  32'(dreq_ready_3),  0);
    chk({tag, " iresp_valid"}, 32'(iresp_valid_3), 0);
    chk({tag, " iresp_data"},  iresp_data_3,       0);
    chk({tag, " dresp_valid"}, 32'(dresp_valid_3), 0);
    chk({tag, " dresp_data"},  dresp_data_3,       0);
    chk({tag, " mem_en"},      32'(mem_en_3),      0);
    chk({tag, " mem_we"},      32'(mem_we_3),      0);
    chk({tag, " mem_addr"},    mem_addr_3,         0);
    chk({tag, " mem_wdata"},   mem_wdata_3,        0);
    chk({tag, " stall"},       32'(stall_3),       0);
  endtask

  initial begin
    //         rst iv iaddr    dv we   daddr    dwdata        fl  ir dr en we   addr     wdata         st iv id            dv dd
    vec[0]  = '{1, 1, 32'h0,   1, 4'h0, 32'h100, 32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,        0, 32'h0};
    vec[1]  = '{1, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[2]  = '{0, 1, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  1, 0, 1, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[3]  = '{0, 1, 32'h4,   0, 4'h0, 32'h0,   32'h0,        0,  1, 0, 1, 4'h0, 32'h4,   32'h0,        0, 1, 32'hA0000000, 0, 32'h0};
    vec[4]  = '{0, 1, 32'h8,   0, 4'h0, 32'h0,   32'h0,        0,  1, 0, 1, 4'h0, 32'h8,   32'h0,        0, 1, 32'hA0000004, 0, 32'h0};
    vec[5]  = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hA0000008, 0, 32'h0};
    vec[6]  = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[7]  = '{0, 1, 32'h10,  1, 4'h0, 32'h100, 32'h0,        0,  0, 1, 1, 4'h0, 32'h100, 32'h0,        1, 0, 32'h0,        0, 32'h0};
    vec[8]  = '{0, 1, 32'h10,  0, 4'h0, 32'h0,   32'h0,        0,  1, 0, 1, 4'h0, 32'h10,  32'h0,        0, 0, 32'h0,        1, 32'hA0000100};
    vec[9]  = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hA0000010, 0, 32'h0};
    vec[10] = '{0, 0, 32'h0,   1, 4'hF, 32'h20,  32'hDEADBEEF, 0,  0, 1, 1, 4'hF, 32'h20,  32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0};
    vec[11] = '{0, 0, 32'h0,   1, 4'h0, 32'h20,  32'h0,        0,  0, 1, 1, 4'h0, 32'h20,  32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[12] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 32'hDEADBEEF};
    vec[13] = '{0, 0, 32'h0,   1, 4'h3, 32'h20,  32'h11112222, 0,  0, 1, 1, 4'h3, 32'h20,  32'h11112222, 0, 0, 32'h0,        0, 32'h0};
    vec[14] = '{0, 0, 32'h0,   1, 4'h0, 32'h20,  32'h0,        0,  0, 1, 1, 4'h0, 32'h20,  32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[15] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 32'hDEAD2222};
    vec[16] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[17] = '{0, 1, 32'h30,  0, 4'h0, 32'h0,   32'h0,        0,  1, 0, 1, 4'h0, 32'h30,  32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[18] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        1,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[19] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[20] = '{0, 0, 32'h0,   1, 4'h0, 32'h100, 32'h0,        0,  0, 1, 1, 4'h0, 32'h100, 32'h0,        0, 0, 32'h0,        0, 32'h0};
    vec[21] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        1,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 32'hA0000100};
    vec[22] = '{0, 0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};

    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Table: one row per cycle on the latency-1 instance.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vec[i].rst, vec[i].ivld, vec[i].iaddr, vec[i].dvld, vec[i].dwe,
            vec[i].daddr, vec[i].dwdata, vec[i].flush);
      #1;
      chk($sformatf("v%0d ireq_ready", i),  32'(ireq_ready_1),  32'(vec[i].e_ir));
      chk($sformatf("v%0d dreq_ready", i),  32'(dreq_ready_1),  32'(vec[i].e_dr));
      chk($sformatf("v%0d mem_en", i),      32'(mem_en_1),      32'(vec[i].e_en));
      chk($sformatf("v%0d mem_we", i),      32'(mem_we_1),      32'(vec[i].e_we));
      chk($sformatf("v%0d mem_addr", i),    mem_addr_1,         vec[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i),   mem_wdata_1,        vec[i].e_wdata);
      chk($sformatf("v%0d stall", i),       32'(stall_1),       32'(vec[i].e_stall));
      chk($sformatf("v%0d iresp_valid", i), 32'(iresp_valid_1), 32'(vec[i].e_iv));
      chk($sformatf("v%0d iresp_data", i),  iresp_data_1,       vec[i].e_id);
      chk($sformatf("v%0d dresp_valid", i), 32'(dresp_valid_1), 32'(vec[i].e_dv));
      chk($sformatf("v%0d dresp_data", i),  dresp_data_1,       vec[i].e_dd);
    end

    // Starvation: data held with fetch pending; fetch wins only on the 5th cycle.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, 1, 32'h44, 1, 4'h0, 32'h40, 32'h0, 0);
      #1;
      chk($sformatf("starve c%0d ireq_ready", c), 32'(ireq_ready_1), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve c%0d dreq_ready", c), 32'(dreq_ready_1), (c == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve c%0d mem_addr", c),   mem_addr_1,        (c == 4) ? 32'h44 : 32'h40);
      chk($sformatf("starve c%0d stall", c),      32'(stall_1),      32'd1);
    end
    idle_cycles(5);

    // Flush on the latency-3 instance: two fetches and a load in flight.
    @(negedge clk); drive(0, 1, 32'h0, 0, 0, 0, 0, 0);
    #1; chk("fl c0 ireq_ready", 32'(ireq_ready_3), 1);
    @(negedge clk); drive(0, 1, 32'h4, 0, 0, 0, 0, 0);
    #1; chk("fl c1 ireq_ready", 32'(ireq_ready_3), 1);
    @(negedge clk); drive(0, 0, 0, 1, 4'h0, 32'h100, 0, 0);
    #1; chk("fl c2 dreq_ready", 32'(dreq_ready_3), 1);
    @(negedge clk); drive(0, 1, 32'h8, 0, 0, 0, 0, 1);
    #1;
    chk("fl c3 ireq_ready", 32'(ireq_ready_3), 1);
    chk("fl c3 iresp_valid", 32'(iresp_valid_3), 0);
    chk("fl c3 iresp_data", iresp_data_3, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl c4 iresp_valid", 32'(iresp_valid_3), 0);
    chk("fl c4 dresp_valid", 32'(dresp_valid_3), 0);
    @(negedge clk);
    #1;
    chk("fl c5 iresp_valid", 32'(iresp_valid_3), 0);
    chk("fl c5 dresp_valid", 32'(dresp_valid_3), 1);
    chk("fl c5 dresp_data", dresp_data_3, 32'hA0000100);
    @(negedge clk);
    #1;
    chk("fl c6 iresp_valid", 32'(iresp_valid_3), 1);
    chk("fl c6 iresp_data", iresp_data_3, 32'hA0000008);
    chk("fl c6 dresp_valid", 32'(dresp_valid_3), 0);
    @(negedge clk);
    #1; chk3_zero("fl c7");
    idle_cycles(2);

    // Reset with a fetch and a load in flight on the latency-3 instance.
    @(negedge clk); drive(0, 1, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 4'h0, 32'h100, 0, 0);
    @(negedge clk); drive(1, 1, 32'hC, 0, 0, 0, 0, 0);
    #1;
    chk("rst ireq_ready", 32'(ireq_ready_3), 0);
    chk("rst mem_en", 32'(mem_en_3), 0);
    chk("rst iresp_valid", 32'(iresp_valid_3), 0);
    chk("rst dresp_valid", 32'(dresp_valid_3), 0);
    chk("rst stall", 32'(stall_3), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1; chk3_zero($sformatf("post-rst c%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
